fir_filter_mac: RTL and testbench

FIR_FILTER_MAC -- requirements
Module: fir_filter_mac

---
 rtl/fir_filter_mac.sv | 75 +++++++
 tb/tb_fir_filter_mac.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fir_filter_mac.sv
// fir_filter_mac: TAPS-tap FIR filter built around one time-multiplexed multiply-accumulate unit.
module fir_filter_mac #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 8,
  parameter int OUT_W  = DATA_W + COEF_W + $clog2(TAPS),
  parameter int AW     = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     busy
);
  localparam int KW = $clog2(TAPS);
  localparam int PW = DATA_W + COEF_W;
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state, state_d;
  logic [KW-1:0] k;
  logic signed [OUT_W-1:0] acc, sum;
  logic signed [PW-1:0] prod;
  logic signed [DATA_W-1:0] x [TAPS];
  logic signed [COEF_W-1:0] h [TAPS];
  logic accept, last, done, coef_ok;
  assign in_ready  = state == IDLE && !rst;
  assign out_valid = state == OUT;
  assign busy      = state != IDLE;
  assign accept    = in_valid && in_ready;
  assign last      = state == MAC && k == KW'(TAPS - 1);
  assign done      = out_valid && out_ready;
  // Widened compare so addresses beyond TAPS are rejected even when AW exceeds the tap count width.
  assign coef_ok   = coef_we && state == IDLE && {1'b0, coef_addr} < (AW + 1)'(TAPS);
  assign prod      = PW'(h[k]) * PW'(x[k]);
  assign sum       = acc + OUT_W'(prod);
  always_comb begin
    state_d = state;
    if (state == IDLE && accept) state_d = MAC;
    else if (last) state_d = OUT;
    else if (done) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k        <= '0;
      acc      <= '0;
      out_data <= '0;
      for (int i = 0; i < TAPS; i++) begin
        x[i] <= '0;
        h[i] <= COEF_W'(i == 0);
      end
    end else begin
      if (accept) begin
        x[0] <= in_data;
        for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
        k   <= '0;
        acc <= '0;
      end else if (state == MAC) begin
        acc <= sum;
        k   <= k + 1'b1;
        if (last) out_data <= sum;
      end
      for (int i = 0; i < TAPS; i++)
        if (coef_ok && coef_addr == AW'(i)) h[i] <= coef_data;
    end
  end
endmodule

// File: tb/tb_fir_filter_mac.sv
// tb_fir_filter_mac: scoreboard bench for fir_filter_mac with a reference delay-line/coefficient model.
module tb_fir_filter_mac;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, coef_we = 0, out_valid, out_ready = 1, busy;
  logic signed [7:0] in_data = 0, coef_data = 0;
  logic [3:0] coef_addr = 0;
  logic signed [18:0] out_data;
  int n_cmp = 0, n_bad = 0;
  longint q [$];
  longint last_out;
  int xm [8], hm [8];

  fir_filter_mac #(.AW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("out_q", q.size(), 1);
      else begin
        chk("out", out_data, q.pop_front());
        last_out = out_data;
      end
    end

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 8; i++) begin
      xm[i] = 0;
      hm[i] = (i == 0) ? 1 : 0;
    end
  endtask

  task automatic pulse_rst();
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1 chk("ready_after_rst", in_ready, 1);
  endtask

  task automatic send(input int d);
    int n = 0;
    longint y = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      chk("ready_timeout", in_ready, 1);
      return;
    end
    in_valid = 1;
    in_data = 8'(d);
    @(posedge clk); #1;
    in_valid = 0;
    for (int i = 7; i > 0; i--) xm[i] = xm[i-1];
    xm[0] = d;
    for (int i = 0; i < 8; i++) y += longint'(hm[i]) * longint'(xm[i]);
    q.push_back(y);
  endtask

  task automatic wcoef(input int a, input int d, input bit take);
    coef_we = 1;
    coef_addr = 4'(a);
    coef_data = 8'(d);
    @(posedge clk); #1;
    coef_we = 0;
    if (take) hm[a] = d;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("drain", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int first, rdy, n;
    longint hold;
    model_reset();
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    rst = 0;
    #1 chk("ready_after_rst", in_ready, 1);
    foreach (xm[i]) xm[i] = 0;

    send(5);
    first = 0; rdy = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (out_valid && first == 0) first = c;
      if (in_ready) begin rdy = c; break; end
    end
    chk("latency", first, 8);
    chk("ready_gap", rdy, 9);
    send(-3);
    drain();
    chk("identity_last", last_out, -3);

    pulse_rst();
    wcoef(0, 1, 1); wcoef(1, 2, 1); wcoef(2, 1, 1);
    for (int i = 0; i < 5; i++) send(10);
    drain();
    chk("step_last", last_out, 40);

    out_ready = 0;
    send(33);
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("stall_valid", out_valid, 1);
    hold = out_data;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("stall_hold", {out_valid, in_ready}, 2'b10);
      chk("stall_data", out_data, hold);
    end
    out_ready = 1;
    send(44);
    drain();

    pulse_rst();
    for (int i = 0; i < 8; i++) wcoef(i, -128, 1);
    for (int i = 0; i < 8; i++) send(-128);
    drain();
    chk("full_scale", last_out, 131072);

    pulse_rst();
    send(3);
    wcoef(0, 7, 0);
    send(4);
    drain();
    wcoef(9, 5, 0);
    send(6);
    drain();
    chk("ignored_writes", last_out, 6);

    send(50);
    repeat (3) begin @(posedge clk); #1; end
    pulse_rst();
    send(1);
    drain();
    chk("impulse_after_rst", last_out, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
